// File: rtl/uart_tx.sv
// UART transmit serializer: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Ports: clk, rst (sync, active-high), baud_tick, tx_data/tx_valid/tx_ready, tx, tx_busy.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_ready;
  logic                 w_ready_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [IW-1:0]        w_idx_inc;
  logic                 r_stop;
  logic                 w_stop_nxt;
  logic                 w_accept;

  // r_ready is only ever high in IDLE, so it doubles as the state qualifier.
  assign w_accept  = tx_valid && r_ready;
  assign w_idx_inc = r_idx + 1'b1;

`ifdef UART_TX_PARITY_EN
  logic w_par;
  assign w_par = (^r_data) ^ (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop;
    unique case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_data_nxt  = tx_data;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SYNC;
        end
      end
      // Any tick seen here arrived after the accept edge, so
      // the start bit that follows always lasts a full period.
      S_SYNC: begin
        if (baud_tick) begin
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_tx_nxt    = r_data[0];
          w_idx_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_idx != LAST_IDX) begin
            w_idx_nxt = w_idx_inc;
            w_tx_nxt  = r_data[w_idx_inc];
          end else begin
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = w_par;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_stop_nxt  = 1'b0;
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          w_tx_nxt    = 1'b1;
          w_stop_nxt  = 1'b0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (baud_tick) begin
          if (r_stop == LAST_STOP) begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_nxt = r_stop + 1'b1;
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;

endmodule
